// File: rtl/sha_feeder_pkg.sv
// Shared types and constants for the SHA-256 APB feeder and its transfer engine.
// Pure declarations: no latency, no backpressure.
package sha_feeder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_IDLE_WAIT,
      ST_WR_MSG,
      ST_WR_CTRL,
      ST_POLL,
      ST_RD_DIG,
      ST_OUT,
      ST_ERR
   } feeder_state_t;

   typedef enum logic [1:0] {
      XF_IDLE,
      XF_SETUP,
      XF_ACCESS
   } xfer_state_t;

   localparam logic [31:0] CTRL_INIT = 32'h1;
   localparam logic [31:0] CTRL_NEXT = 32'h2;
   localparam int          STAT_DONE = 0;
   localparam int          MSG_WORDS = 16;
   localparam int          DIG_WORDS = 8;
   localparam logic [3:0]  MSG_LAST  = 4'(MSG_WORDS - 1);
   localparam logic [2:0]  DIG_LAST  = 3'(DIG_WORDS - 1);

   // Byte address of 32-bit word idx above base.
   function automatic logic [11:0] word_addr(input logic [11:0] base, input logic [3:0] idx);
      return base + {6'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// Single APB transfer engine: req in idle -> SETUP -> ACCESS until PREADY.
// Latency: 2 cycles at zero wait; done pulses combinationally in the completing ACCESS cycle.
// Backpressure: req is ignored while a transfer is in flight; PREADY=0 extends ACCESS.
module apb_master_xfer
   import sha_feeder_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [11:0] addr,
   input  logic [31:0] wdata,
   input  logic        write,
   output logic        done,
   output logic [31:0] rdata,
   output logic        slverr,
   output logic [11:0] PADDR_o,
   output logic [31:0] PWDATA_o,
   output logic        PWRITE_o,
   output logic        PSEL_o,
   output logic        PENABLE_o,
   input  logic [31:0] PRDATA_i,
   input  logic        PREADY_i,
   input  logic        PSLVERR_i
);

   xfer_state_t state_q, state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= XF_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         XF_IDLE:   if (req) state_d = XF_SETUP;
         XF_SETUP:  state_d = XF_ACCESS;
         XF_ACCESS: if (PREADY_i) state_d = XF_IDLE;
         default:   state_d = XF_IDLE;
      endcase
   end

   // Address/data captured once at request so they stay stable through any wait states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PADDR_o  <= '0;
         PWDATA_o <= '0;
         PWRITE_o <= 1'b0;
      end else if (state_q == XF_IDLE && req) begin
         PADDR_o  <= addr;
         PWDATA_o <= wdata;
         PWRITE_o <= write;
      end
   end

   assign PSEL_o    = (state_q != XF_IDLE);
   assign PENABLE_o = (state_q == XF_ACCESS);
   assign done      = PENABLE_o & PREADY_i;
   assign rdata     = PRDATA_i;
   assign slverr    = done & PSLVERR_i;

endmodule

// File: rtl/sha_apb_feeder.sv
// Streams 16-word blocks into the SHA-256 APB slave, kicks INIT/NEXT, polls DONE, streams out the digest.
// Latency: 3 cycles per APB access at zero wait; d_valid rises the cycle after the 8th digest read.
// Backpressure: s_ready only in IDLE/IDLE_WAIT; digest words held stable while d_ready=0.
module sha_apb_feeder
   import sha_feeder_pkg::*;
#(
   parameter logic [11:0] MSG_BASE  = 12'h000,
   parameter logic [11:0] CTRL_ADDR = 12'h040,
   parameter logic [11:0] STAT_ADDR = 12'h044,
   parameter logic [11:0] DIG_BASE  = 12'h080,
   parameter int          POLL_MAX  = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   input  logic        s_last,
   output logic        d_valid,
   input  logic        d_ready,
   output logic [31:0] d_data,
   output logic        d_last,
   output logic        busy_o,
   output logic        err_o,
   output logic [11:0] PADDR_o,
   output logic [31:0] PWDATA_o,
   output logic        PWRITE_o,
   output logic        PSEL_o,
   output logic        PENABLE_o,
   input  logic [31:0] PRDATA_i,
   input  logic        PREADY_i,
   input  logic        PSLVERR_i
);

   localparam logic [10:0] POLL_LAST = 11'(POLL_MAX - 1);

   feeder_state_t state_q, state_d;
   logic [3:0]    cnt_q;
   logic [2:0]    dig_idx_q;
   logic [10:0]   poll_q;
   logic          first_q;
   logic          last_q;
   logic [31:0]   dat_q;
   logic [31:0]   dig_buf [DIG_WORDS];

   logic          xf_req, xf_write, xf_done, xf_slverr;
   logic [11:0]   xf_addr;
   logic [31:0]   xf_wdata, xf_rdata;

   apb_master_xfer u_xfer (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (xf_req),
      .addr      (xf_addr),
      .wdata     (xf_wdata),
      .write     (xf_write),
      .done      (xf_done),
      .rdata     (xf_rdata),
      .slverr    (xf_slverr),
      .PADDR_o   (PADDR_o),
      .PWDATA_o  (PWDATA_o),
      .PWRITE_o  (PWRITE_o),
      .PSEL_o    (PSEL_o),
      .PENABLE_o (PENABLE_o),
      .PRDATA_i  (PRDATA_i),
      .PREADY_i  (PREADY_i),
      .PSLVERR_i (PSLVERR_i)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      s_ready  = 1'b0;
      d_valid  = 1'b0;
      xf_req   = 1'b0;
      xf_addr  = '0;
      xf_wdata = '0;
      xf_write = 1'b0;
      case (state_q)
         ST_IDLE, ST_IDLE_WAIT: begin
            s_ready = 1'b1;
            // A last marker anywhere but word 15 means a malformed message.
            if (s_valid) state_d = (s_last && cnt_q != MSG_LAST) ? ST_ERR : ST_WR_MSG;
         end
         ST_WR_MSG: begin
            xf_req   = 1'b1;
            xf_addr  = word_addr(MSG_BASE, cnt_q);
            xf_wdata = dat_q;
            xf_write = 1'b1;
            if (xf_done) begin
               if (xf_slverr)              state_d = ST_ERR;
               else if (cnt_q == MSG_LAST) state_d = ST_WR_CTRL;
               else                        state_d = ST_IDLE_WAIT;
            end
         end
         ST_WR_CTRL: begin
            xf_req   = 1'b1;
            xf_addr  = CTRL_ADDR;
            xf_wdata = first_q ? CTRL_INIT : CTRL_NEXT;
            xf_write = 1'b1;
            if (xf_done) state_d = xf_slverr ? ST_ERR : ST_POLL;
         end
         ST_POLL: begin
            xf_req  = 1'b1;
            xf_addr = STAT_ADDR;
            if (xf_done) begin
               if (xf_slverr)                state_d = ST_ERR;
               else if (xf_rdata[STAT_DONE]) state_d = last_q ? ST_RD_DIG : ST_IDLE_WAIT;
               else if (poll_q == POLL_LAST) state_d = ST_ERR;
            end
         end
         ST_RD_DIG: begin
            xf_req  = 1'b1;
            xf_addr = word_addr(DIG_BASE, {1'b0, dig_idx_q});
            if (xf_done) begin
               if (xf_slverr)                  state_d = ST_ERR;
               else if (dig_idx_q == DIG_LAST) state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            d_valid = 1'b1;
            if (d_ready && dig_idx_q == DIG_LAST) state_d = ST_IDLE;
         end
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         dig_idx_q <= '0;
         poll_q    <= '0;
         first_q   <= 1'b1;
         last_q    <= 1'b0;
         dat_q     <= '0;
         for (int i = 0; i < DIG_WORDS; i++) dig_buf[i] <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_IDLE_WAIT: begin
               if (s_valid) begin
                  dat_q  <= s_data;
                  last_q <= s_last;
               end
            end
            ST_WR_MSG:  if (xf_done && !xf_slverr) cnt_q <= cnt_q + 4'd1;
            ST_WR_CTRL: begin
               if (xf_done && !xf_slverr) begin
                  first_q <= 1'b0;
                  poll_q  <= '0;
               end
            end
            ST_POLL: if (xf_done && !xf_slverr && !xf_rdata[STAT_DONE]) poll_q <= poll_q + 11'd1;
            ST_RD_DIG: begin
               if (xf_done && !xf_slverr) begin
                  dig_buf[dig_idx_q] <= xf_rdata;
                  dig_idx_q          <= dig_idx_q + 3'd1;
               end
            end
            ST_OUT: begin
               if (d_ready) begin
                  dig_idx_q <= dig_idx_q + 3'd1;
                  if (dig_idx_q == DIG_LAST) first_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign d_data = dig_buf[dig_idx_q];
   assign d_last = (state_q == ST_OUT) && (dig_idx_q == DIG_LAST);
   assign busy_o = (state_q != ST_IDLE);
   assign err_o  = (state_q == ST_ERR);

endmodule

// File: tb/tb_sha_apb_feeder.sv
// Bench for sha_apb_feeder: APB slave model plus scoreboards for APB transfers and digest words.
module tb_sha_apb_feeder;

   typedef struct packed {
      logic [11:0] addr;
      logic        wr;
      logic [31:0] wd;
   } apb_t;

   localparam logic [11:0] A_CTRL = 12'h040;
   localparam logic [11:0] A_STAT = 12'h044;
   localparam logic [11:0] A_DIG  = 12'h080;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        d_valid;
   logic        d_ready = 1'b0;
   logic [31:0] d_data;
   logic        d_last;
   logic        busy_o, err_o;
   logic [11:0] PADDR_o;
   logic [31:0] PWDATA_o;
   logic        PWRITE_o, PSEL_o, PENABLE_o;
   logic [31:0] PRDATA_i = '0;
   logic        PREADY_i = 1'b0;
   logic        PSLVERR_i = 1'b0;

   sha_apb_feeder dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_last(d_last),
      .busy_o(busy_o), .err_o(err_o),
      .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o), .PWRITE_o(PWRITE_o),
      .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o),
      .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scenario knobs and scoreboards
   int          wait_n = 0;
   int          done_after = 2;
   bit          slverr_en = 1'b0;
   logic [11:0] slverr_addr = 12'h014;
   bit          dr_rand = 1'b0;
   apb_t        apb_q[$];
   logic [32:0] dig_q[$];
   logic [31:0] blk [16];
   logic [31:0] dig_tab [8];

   int cyc = 0;
   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1 d_ready = dr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // APB slave model: decides PREADY/PRDATA at the negedge before the completing edge.
   int   wcnt = 0, last_setup = 0, stat_reads = 0, blk_polls = 0;
   bit   prev_psel = 1'b0, lat_arm = 1'b0;
   apb_t snap, act, exp_x;

   always @(negedge clk) begin
      if (!rst_n) begin
         PREADY_i = 1'b0; PSLVERR_i = 1'b0; PRDATA_i = '0;
         wcnt = 0; prev_psel = 1'b0; lat_arm = 1'b0; stat_reads = 0; blk_polls = 0;
      end else begin
         if (lat_arm) begin
            chk_eq("dig_latency", 64'(d_valid), 64'(1));
            lat_arm = 1'b0;
         end
         if (PSEL_o && !PENABLE_o) begin
            chk_eq("psel_gap", 64'(prev_psel), 64'(0));
            snap = {PADDR_o, PWRITE_o, PWDATA_o};
            if (wait_n == 0 && PADDR_o > A_DIG && PADDR_o <= 12'h09C)
               chk_eq("dig_spacing", 64'(cyc - last_setup), 64'(3));
            last_setup = cyc;
            PREADY_i = 1'b0; wcnt = 0;
         end else if (PSEL_o && PENABLE_o) begin
            chk_eq("apb_stable", 64'({PADDR_o, PWRITE_o, PWDATA_o}), 64'(snap));
            if (wcnt < wait_n) begin
               wcnt++;
               PREADY_i = 1'b0;
            end else begin
               act = {PADDR_o, PWRITE_o, PWRITE_o ? PWDATA_o : 32'h0};
               if (apb_q.size() == 0) chk_eq("apb_extra", 64'(act), 64'('1));
               else begin
                  exp_x = apb_q.pop_front();
                  chk_eq("apb_xfer", 64'(act), 64'(exp_x));
               end
               PSLVERR_i = slverr_en && (PADDR_o == slverr_addr);
               PRDATA_i = '0;
               if (PWRITE_o && PADDR_o == A_CTRL) blk_polls = 0;
               if (!PWRITE_o && PADDR_o == A_STAT) begin
                  stat_reads++; blk_polls++;
                  PRDATA_i = (done_after != 0 && blk_polls >= done_after) ? 32'h1 : 32'h0;
               end
               if (!PWRITE_o && PADDR_o >= A_DIG && PADDR_o <= 12'h09C) begin
                  PRDATA_i = dig_tab[PADDR_o[4:2]];
                  if (PADDR_o == 12'h09C) lat_arm = 1'b1;
               end
               PREADY_i = 1'b1;
            end
         end else begin
            PREADY_i = 1'b0; PSLVERR_i = 1'b0; wcnt = 0;
         end
         prev_psel = PSEL_o;
      end
   end

   // Digest sink monitor
   bit          hold_chk = 1'b0;
   logic [31:0] hold_dat;
   logic [32:0] dexp;

   always @(negedge clk) begin
      if (!rst_n) hold_chk = 1'b0;
      else begin
         if (hold_chk) begin
            chk_eq("d_hold", 64'({d_valid, d_data}), 64'({1'b1, hold_dat}));
            hold_chk = 1'b0;
         end
         if (d_valid) begin
            if (d_ready) begin
               if (dig_q.size() == 0) chk_eq("dig_extra", 64'({d_last, d_data}), 64'('1));
               else begin
                  dexp = dig_q.pop_front();
                  chk_eq("dig_word", 64'({d_last, d_data}), 64'(dexp));
               end
            end else begin
               hold_chk = 1'b1;
               hold_dat = d_data;
            end
         end
      end
   end

   task automatic fill_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
   endtask

   task automatic fill_pat(input logic [31:0] seed);
      for (int i = 0; i < 16; i++) blk[i] = seed ^ (32'h01010101 * 32'(i));
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) apb_q.push_back({12'(4 * i), 1'b1, blk[i]});
   endtask

   task automatic push_block(input bit first, input int polls, input bit fin);
      push_words(16);
      apb_q.push_back({A_CTRL, 1'b1, first ? 32'h1 : 32'h2});
      for (int p = 0; p < polls; p++) apb_q.push_back({A_STAT, 1'b0, 32'h0});
      if (fin) begin
         for (int j = 0; j < 8; j++) begin
            apb_q.push_back({12'(A_DIG + 12'(4 * j)), 1'b0, 32'h0});
            dig_q.push_back({(j == 7), dig_tab[j]});
         end
      end
   endtask

   task automatic send_word(input logic [31:0] d, input logic l);
      bit acc, ok;
      ok = 1'b0;
      s_valid = 1'b1; s_data = d; s_last = l;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk); acc = s_ready;
         @(posedge clk);
         if (acc) begin ok = 1'b1; break; end
      end
      #1 s_valid = 1'b0; s_last = 1'b0;
      chk_eq("s_handshake", 64'(ok), 64'(1));
   endtask

   task automatic send_block(input bit fin, input int n);
      for (int i = 0; i < n; i++) send_word(blk[i], fin && i == 15);
   endtask

   task automatic wait_done(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (apb_q.size() == 0 && dig_q.size() == 0 && !busy_o) begin ok = 1'b1; break; end
      end
      chk_eq(tag, 64'(ok), 64'(1));
      chk_eq("no_err", 64'(err_o), 64'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      apb_q.delete(); dig_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found, seen;
      dig_tab[0] = 32'hba7816bf; dig_tab[1] = 32'h8f01cfea;
      dig_tab[2] = 32'h414140de; dig_tab[3] = 32'h5dae2223;
      dig_tab[4] = 32'hb00361a3; dig_tab[5] = 32'h96177a9c;
      dig_tab[6] = 32'hb410ff61; dig_tab[7] = 32'hf20015ad;

      repeat (2) @(posedge clk); #1;
      chk_eq("rst_apb", 64'({PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o}), 64'(0));
      chk_eq("rst_flags", 64'({d_valid, d_last, busy_o, err_o}), 64'(0));
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single block "abc", zero wait states
      wait_n = 0; done_after = 2;
      fill_abc(); push_block(1'b1, 2, 1'b1); send_block(1'b1, 16);
      wait_done("abc_done");
      chk_eq("abc_stat_reads", 64'(stat_reads), 64'(2));

      // Two-block message then a fresh message restarting with INIT
      done_after = 3;
      fill_pat(32'hdeadbeef); push_block(1'b1, 3, 1'b0); send_block(1'b0, 16);
      fill_abc(); push_block(1'b0, 3, 1'b1); send_block(1'b1, 16);
      wait_done("two_blk_done");
      fill_abc(); push_block(1'b1, 3, 1'b1); send_block(1'b1, 16);
      wait_done("restart_done");

      // Wait states on every transfer and random digest backpressure
      wait_n = 3; dr_rand = 1'b1; done_after = 2;
      fill_abc(); push_block(1'b1, 2, 1'b1); send_block(1'b1, 16);
      wait_done("wait_done");
      wait_n = 0; dr_rand = 1'b0;

      // STATUS never reports DONE
      done_after = 0;
      do_reset();
      fill_pat(32'h12345678); push_block(1'b1, 1024, 1'b0); send_block(1'b1, 16);
      found = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk); #1;
         if (err_o) begin found = 1'b1; break; end
      end
      chk_eq("to_err", 64'(found), 64'(1));
      chk_eq("to_reads", 64'(stat_reads), 64'(1024));
      chk_eq("to_q_empty", 64'(apb_q.size()), 64'(0));
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (PSEL_o || s_ready) seen = 1'b1;
      end
      chk_eq("to_quiet", 64'(seen), 64'(0));

      // PSLVERR on message word 5
      done_after = 2; slverr_en = 1'b1; slverr_addr = 12'h014;
      do_reset();
      fill_pat(32'hcafef00d); push_words(6); send_block(1'b0, 6);
      repeat (10) @(posedge clk); #1;
      chk_eq("se_err", 64'({err_o, s_ready, busy_o}), 64'(3'b101));
      chk_eq("se_q_empty", 64'(apb_q.size()), 64'(0));
      slverr_en = 1'b0;

      // Async reset during ACCESS of word 7
      wait_n = 3;
      do_reset();
      fill_pat(32'h0badc0de); push_words(7); send_block(1'b0, 8);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (PSEL_o && PENABLE_o && PADDR_o == 12'h01C) begin found = 1'b1; break; end
      end
      chk_eq("ar_found", 64'(found), 64'(1));
      rst_n = 1'b0;
      #1;
      chk_eq("ar_apb_drop", 64'({PSEL_o, PENABLE_o}), 64'(0));
      chk_eq("ar_q_empty", 64'(apb_q.size()), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_n = 0;
      fill_abc(); push_block(1'b1, 2, 1'b1); send_block(1'b1, 16);
      wait_done("ar_fresh_done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
